pipeline_hazard_ctrl: RTL

- Central stall/flush initiator for the five-stage pipeline.
- Drives the `stall`/`flush` inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers and the PC hold/redirect. Those registers honour `flush` only when `stall` is low.
- Detects load-use hazards, branch mispredicts, traps and memory busy conditions.
- Sequences `fence`/`fence.i` through a drain → cache-flush → resume state machine.

---
 rtl/pipe_ctrl_pkg.sv | 55 +++++
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
// Holds the fence FSM states, the RUN-state action priority and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH,
        ST_RESUME
    } state_e;

    // Encoded in priority order: a lower-numbered active action masks every later one.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_TRAP,
        ACT_MEM_BUSY,
        ACT_MISPREDICT,
        ACT_FENCE,
        ACT_LOAD_USE,
        ACT_IF_BUSY
    } action_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idexe;
        logic stall_exemem;
        logic stall_memwb;
        logic flush_ifid;
        logic flush_idexe;
        logic flush_exemem;
        logic flush_memwb;
    } pipe_ctl_t;

    function automatic action_e run_action(
        input logic trap,
        input logic mem_busy,
        input logic mispredict,
        input logic fence,
        input logic load_use,
        input logic if_busy
    );
        if (trap)            return ACT_TRAP;
        else if (mem_busy)   return ACT_MEM_BUSY;
        else if (mispredict) return ACT_MISPREDICT;
        else if (fence)      return ACT_FENCE;
        else if (load_use)   return ACT_LOAD_USE;
        else if (if_busy)    return ACT_IF_BUSY;
        else                 return ACT_NONE;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EXE and the sources read in ID.
// Kept standalone so forwarding logic can share the same register match.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  valid_exe,
    input  logic                  is_load_exe,
    input  logic [REG_ADDR_W-1:0] rd_exe,
    input  logic                  valid_id,
    input  logic                  use_rs1_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic                  use_rs2_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = use_rs1_id && (rs1_id == rd_exe);
    assign rs2_hit  = use_rs2_id && (rs2_id == rd_exe);
    // x0 is never written, so a load targeting it can never create a dependency.
    assign load_use = valid_exe && is_load_exe && (rd_exe != '0) && valid_id && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/redirect source for the five-stage pipeline, including the
// fence drain -> cache-flush -> resume sequencer and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  valid_exe,
    input  logic                  is_load_exe,
    input  logic                  fence_exe,
    input  logic [REG_ADDR_W-1:0] rd_exe,
    input  logic [XLEN-1:0]       pc_exe,
    input  logic [XLEN-1:0]       npc_exe,
    input  logic [XLEN-1:0]       predict_pc_exe,
    input  logic                  if_busy,
    input  logic                  mem_busy,
    input  logic                  trap_valid_wb,
    input  logic [XLEN-1:0]       trap_pc_wb,
    input  logic                  cache_flush_done,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_idexe,
    output logic                  stall_exemem,
    output logic                  stall_memwb,
    output logic                  flush_ifid,
    output logic                  flush_idexe,
    output logic                  flush_exemem,
    output logic                  flush_memwb,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  cache_flush_req,
    output logic                  ctrl_busy,
    output logic [CNT_W-1:0]      perf_stall_cnt
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    state_e            state, state_next;
    logic [DW-1:0]     drain_cnt, drain_cnt_next;
    logic [XLEN-1:0]   fence_pc, fence_pc_next;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_ctl_t         ctl;
    logic              redir_v;
    logic [XLEN-1:0]   redir_pc;
    logic              flush_req;
    logic              load_use;
    logic              mispredict;
    logic              fence_take;
    action_e           act;

    load_use_detect u_load_use (
        .valid_exe   (valid_exe),
        .is_load_exe (is_load_exe),
        .rd_exe      (rd_exe),
        .valid_id    (valid_id),
        .use_rs1_id  (use_rs1_id),
        .rs1_id      (rs1_id),
        .use_rs2_id  (use_rs2_id),
        .rs2_id      (rs2_id),
        .load_use    (load_use)
    );

    assign mispredict = valid_exe && (npc_exe != predict_pc_exe);
    assign fence_take = valid_exe && fence_exe;
    assign act        = run_action(trap_valid_wb, mem_busy, mispredict, fence_take, load_use, if_busy);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        ctl            = '0;
        redir_v        = 1'b0;
        redir_pc       = '0;
        flush_req      = 1'b0;
        state_next     = state;
        drain_cnt_next = drain_cnt;
        fence_pc_next  = fence_pc;

        unique case (state)
            ST_RUN: begin
                case (act)
                    ACT_TRAP: begin
                        ctl.flush_ifid   = 1'b1;
                        ctl.flush_idexe  = 1'b1;
                        ctl.flush_exemem = 1'b1;
                        ctl.flush_memwb  = 1'b1;
                        redir_v          = 1'b1;
                        redir_pc         = trap_pc_wb;
                    end
                    ACT_MEM_BUSY: begin
                        ctl.stall_pc     = 1'b1;
                        ctl.stall_ifid   = 1'b1;
                        ctl.stall_idexe  = 1'b1;
                        ctl.stall_exemem = 1'b1;
                        ctl.stall_memwb  = 1'b1;
                    end
                    // A fence that also mispredicts keeps the redirect/flush outputs; the
                    // fence sequence below still starts and refetches after it completes.
                    ACT_MISPREDICT: begin
                        ctl.flush_ifid  = 1'b1;
                        ctl.flush_idexe = 1'b1;
                        redir_v         = 1'b1;
                        redir_pc        = npc_exe;
                    end
                    ACT_FENCE, ACT_LOAD_USE: begin
                        ctl.stall_pc    = 1'b1;
                        ctl.stall_ifid  = 1'b1;
                        ctl.flush_idexe = 1'b1;
                    end
                    ACT_IF_BUSY: begin
                        ctl.stall_pc   = 1'b1;
                        ctl.flush_ifid = 1'b1;
                    end
                    default: ;
                endcase
                if (act == ACT_FENCE || (act == ACT_MISPREDICT && fence_take)) begin
                    fence_pc_next  = pc_exe;
                    drain_cnt_next = DRAIN_LOAD;
                    state_next     = (DRAIN_CYCLES == 0) ? ST_FLUSH : ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (trap_valid_wb) begin
                    ctl.flush_ifid   = 1'b1;
                    ctl.flush_idexe  = 1'b1;
                    ctl.flush_exemem = 1'b1;
                    ctl.flush_memwb  = 1'b1;
                    redir_v          = 1'b1;
                    redir_pc         = trap_pc_wb;
                    drain_cnt_next   = '0;
                    state_next       = ST_RUN;
                end else begin
                    ctl.stall_pc     = 1'b1;
                    ctl.stall_ifid   = 1'b1;
                    ctl.flush_idexe  = 1'b1;
                    ctl.stall_exemem = mem_busy;
                    ctl.stall_memwb  = mem_busy;
                    if (!mem_busy) begin
                        if (drain_cnt <= DW'(1)) begin
                            drain_cnt_next = '0;
                            state_next     = ST_FLUSH;
                        end else begin
                            drain_cnt_next = drain_cnt - DW'(1);
                        end
                    end
                end
            end

            ST_FLUSH: begin
                flush_req       = 1'b1;
                ctl.stall_pc    = 1'b1;
                ctl.stall_ifid  = 1'b1;
                ctl.flush_idexe = 1'b1;
                if (cache_flush_done) begin
                    state_next = ST_RESUME;
                end
            end

            ST_RESUME: begin
                ctl.flush_ifid  = 1'b1;
                ctl.flush_idexe = 1'b1;
                redir_v         = 1'b1;
                redir_pc        = fence_pc + XLEN'(PC_STEP);
                state_next      = ST_RUN;
            end
        endcase

        if (rst) begin
            ctl       = '0;
            redir_v   = 1'b0;
            redir_pc  = '0;
            flush_req = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            fence_pc  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            fence_pc  <= fence_pc_next;
            if (ctl.stall_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign stall_pc        = ctl.stall_pc;
    assign stall_ifid      = ctl.stall_ifid;
    assign stall_idexe     = ctl.stall_idexe;
    assign stall_exemem    = ctl.stall_exemem;
    assign stall_memwb     = ctl.stall_memwb;
    assign flush_ifid      = ctl.flush_ifid;
    assign flush_idexe     = ctl.flush_idexe;
    assign flush_exemem    = ctl.flush_exemem;
    assign flush_memwb     = ctl.flush_memwb;
    assign redirect_valid  = redir_v;
    assign redirect_pc     = redir_pc;
    assign cache_flush_req = flush_req;
    assign ctrl_busy       = (state != ST_RUN) && !rst;
    assign perf_stall_cnt  = stall_cnt;

endmodule
